// File: rtl/ntt_ctrl_pkg.sv
// ntt_ctrl_pkg
// Shared definitions for the MDC NTT sequencer: FSM state encoding,
// a constant-evaluable ceil(log2) helper and the default watchdog limit.
package ntt_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FEED  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

    localparam int DEFAULT_TIMEOUT = 4096;

    // Smallest r with 2**r >= v; used to size counters at elaboration.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ntt_ctrl_vdelay.sv
// ntt_ctrl_vdelay
// 1-bit shift register of depth DEPTH. Delays the coefficient-RAM read
// enable so that it lines up with the returned read data.
// Ports:
//   clk      system clock
//   rst      synchronous active-high reset (clears every stage)
//   i_valid  undelayed valid
//   o_valid  i_valid delayed by DEPTH cycles
module ntt_ctrl_vdelay #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_valid,
    output logic o_valid
);

    logic [DEPTH-1:0] r_sr;

    generate
        if (DEPTH == 1) begin : g_one
            always_ff @(posedge clk) begin
                if (rst) r_sr <= 1'b0;
                else     r_sr <= i_valid;
            end
        end else begin : g_many
            always_ff @(posedge clk) begin
                if (rst) r_sr <= '0;
                else     r_sr <= {r_sr[DEPTH-2:0], i_valid};
            end
        end
    endgenerate

    assign o_valid = r_sr[DEPTH-1];

endmodule

// File: rtl/ntt_mdc_ctrl.sv
// ntt_mdc_ctrl
// Runs one full polynomial transform through the MDC NTT pipeline:
// accepts a command, streams N/2 coefficient pairs from the coefficient RAM
// into the pipeline with a start pulse on the first pair, then writes the
// N/2 output pairs that follow the pipeline's finish pulse into the result
// RAM. A watchdog aborts with err if finish does not arrive in time.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cmd_valid/cmd_intt/cmd_ready  command request, mode, accept (IDLE only)
//   busy, done, err               status; done is a pulse, err valid with done
//   rd_en/rd_addr/rd_data_*       coefficient RAM, DELAY_BRAM read latency
//   ntt_start/ntt_intt/ntt_in_*   pipeline input side
//   ntt_finish/ntt_out_*          pipeline output side
//   wr_en/wr_addr/wr_data_*       result RAM write port
//   dbg_state                     current FSM state
// Handshake: a command transfers on a cycle where cmd_valid and cmd_ready
// are both high; the requester holds cmd_valid until that happens.
module ntt_mdc_ctrl
    import ntt_ctrl_pkg::*;
#(
    parameter int LOGQ       = 64,
    parameter int LOGN       = 8,
    parameter int DELAY_BRAM = 2,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    input  logic            cmd_intt,
    output logic            cmd_ready,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic            rd_en,
    output logic [LOGN-2:0] rd_addr,
    input  logic [LOGQ-1:0] rd_data_0,
    input  logic [LOGQ-1:0] rd_data_1,
    output logic            ntt_start,
    output logic            ntt_intt,
    output logic [LOGQ-1:0] ntt_in_0,
    output logic [LOGQ-1:0] ntt_in_1,
    input  logic            ntt_finish,
    input  logic [LOGQ-1:0] ntt_out_0,
    input  logic [LOGQ-1:0] ntt_out_1,
    output logic            wr_en,
    output logic [LOGN-2:0] wr_addr,
    output logic [LOGQ-1:0] wr_data_0,
    output logic [LOGQ-1:0] wr_data_1,
    output logic [2:0]      dbg_state
);

    localparam int AW  = LOGN - 1;
    localparam int NP  = 1 << (LOGN - 1);
    localparam int WDW = clog2(TIMEOUT + 1);

    state_t          r_state, w_next;
    logic            r_rd_act;
    logic [AW-1:0]   r_rd_cnt;
    logic [AW-1:0]   r_wr_cnt;
    logic [WDW-1:0]  r_wd;
    logic            r_wd_run;
    logic            r_vd_q;
    logic            r_intt;
    logic            r_err;

    logic            w_dvalid;
    logic            w_start;
    logic            w_waiting;
    logic            w_fin_hit;
    logic            w_timeout;
    logic            w_accept;

    ntt_ctrl_vdelay #(.DEPTH(DELAY_BRAM)) u_vdelay (
        .clk     (clk),
        .rst     (rst),
        .i_valid (r_rd_act),
        .o_valid (w_dvalid)
    );

    assign w_accept  = (r_state == ST_IDLE) && cmd_valid;
    // The delayed valid is one contiguous burst per op, so its rising edge
    // marks the first pair.
    assign w_start   = w_dvalid && !r_vd_q;
    // Finish/timeout are watched from the start pulse onward, which can fall
    // inside FEED as well as WAIT.
    assign w_waiting = r_wd_run && ((r_state == ST_FEED) || (r_state == ST_WAIT));
    assign w_fin_hit = w_waiting && ntt_finish;
    assign w_timeout = w_waiting && !ntt_finish && (r_wd == WDW'(TIMEOUT));

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (cmd_valid) w_next = ST_FEED;
            ST_FEED: begin
                if (w_fin_hit)                       w_next = ST_DRAIN;
                else if (w_timeout)                  w_next = ST_FIN;
                else if (r_rd_cnt == AW'(NP - 1))    w_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_fin_hit)      w_next = ST_DRAIN;
                else if (w_timeout) w_next = ST_FIN;
            end
            ST_DRAIN: if (r_wr_cnt == AW'(NP - 1)) w_next = ST_FIN;
            ST_FIN:   w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_rd_act <= 1'b0;
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
            r_wd     <= '0;
            r_wd_run <= 1'b0;
            r_vd_q   <= 1'b0;
            r_intt   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_vd_q  <= w_dvalid;

            if (w_accept) begin
                r_intt   <= cmd_intt;
                r_err    <= 1'b0;
                r_rd_act <= 1'b1;
                r_rd_cnt <= '0;
            end else if (w_next == ST_FIN) begin
                // An abort can land while reads are still running.
                r_rd_act <= 1'b0;
            end else if (r_rd_act) begin
                if (r_rd_cnt == AW'(NP - 1)) r_rd_act <= 1'b0;
                else                         r_rd_cnt <= r_rd_cnt + AW'(1);
            end

            if (w_timeout) r_err <= 1'b1;

            // Watchdog holds k on the k-th cycle after the start pulse.
            if (w_start) begin
                r_wd     <= WDW'(1);
                r_wd_run <= 1'b1;
            end else if (r_state == ST_FIN) begin
                r_wd_run <= 1'b0;
            end else if (r_wd_run && (r_wd != WDW'(TIMEOUT))) begin
                r_wd <= r_wd + WDW'(1);
            end

            // Pair 0 is written on the finish cycle itself.
            if (w_fin_hit) begin
                r_wr_cnt <= AW'(1);
            end else if ((r_state == ST_DRAIN) && (r_wr_cnt != AW'(NP - 1))) begin
                r_wr_cnt <= r_wr_cnt + AW'(1);
            end
        end
    end

    assign cmd_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_FIN);
    assign err       = (r_state == ST_FIN) && r_err;
    assign rd_en     = r_rd_act;
    assign rd_addr   = r_rd_cnt;
    assign ntt_start = w_start;
    assign ntt_intt  = r_intt;
    assign ntt_in_0  = w_dvalid ? rd_data_0 : '0;
    assign ntt_in_1  = w_dvalid ? rd_data_1 : '0;
    assign wr_en     = (r_state == ST_DRAIN) || w_fin_hit;
    assign wr_addr   = (r_state == ST_DRAIN) ? r_wr_cnt : '0;
    assign wr_data_0 = wr_en ? ntt_out_0 : '0;
    assign wr_data_1 = wr_en ? ntt_out_1 : '0;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_ntt_mdc_ctrl.sv
// tb_ntt_mdc_ctrl
// Bench for ntt_mdc_ctrl with LOGN=4 (8 pairs), DELAY_BRAM=2, LOGQ=16,
// TIMEOUT=64. A coefficient RAM model and a pipeline stub (finish 20 cycles
// after start, output = fixed function of each captured input pair) drive
// the DUT; a per-op timeline model predicts every output cycle by cycle.
module tb_ntt_mdc_ctrl;
    import ntt_ctrl_pkg::*;

    localparam int LOGQ = 16;
    localparam int LOGN = 4;
    localparam int D    = 2;
    localparam int TMO  = 64;
    localparam int LAT  = 20;
    localparam int NP   = 8;
    localparam int HMAX = 8192;

    // ---------------- clock / reset ----------------
    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            cmd_valid = 1'b0, cmd_intt = 1'b0;
    logic            cmd_ready, busy, done, err, rd_en, ntt_start, ntt_intt, wr_en;
    logic [LOGN-2:0] rd_addr, wr_addr;
    logic [LOGQ-1:0] rd_data_0 = '0, rd_data_1 = '0;
    logic [LOGQ-1:0] ntt_in_0, ntt_in_1, wr_data_0, wr_data_1;
    logic            ntt_finish = 1'b0;
    logic [LOGQ-1:0] ntt_out_0 = '0, ntt_out_1 = '0;
    logic [2:0]      dbg_state;

    always #5 clk = ~clk;

    ntt_mdc_ctrl #(.LOGQ(LOGQ), .LOGN(LOGN), .DELAY_BRAM(D), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_intt(cmd_intt),
        .cmd_ready(cmd_ready), .busy(busy), .done(done), .err(err),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data_0(rd_data_0), .rd_data_1(rd_data_1),
        .ntt_start(ntt_start), .ntt_intt(ntt_intt), .ntt_in_0(ntt_in_0), .ntt_in_1(ntt_in_1),
        .ntt_finish(ntt_finish), .ntt_out_0(ntt_out_0), .ntt_out_1(ntt_out_1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data_0(wr_data_0), .wr_data_1(wr_data_1),
        .dbg_state(dbg_state)
    );

    // ---------------- bench state ----------------
    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    logic            n_rst = 1'b1, n_valid = 1'b0, n_intt = 1'b0, n_spur = 1'b0;
    logic [LOGQ-1:0] mem0 [NP];
    logic [LOGQ-1:0] mem1 [NP];
    bit              h_rd_en   [HMAX];
    logic [LOGN-2:0] h_rd_addr [HMAX];

    // pipeline stub
    int              p_s = -1000;
    bit              p_fin_en = 1'b1;
    logic [LOGQ-1:0] cap0 [NP];
    logic [LOGQ-1:0] cap1 [NP];

    // op timeline model
    bit m_act = 1'b0, m_intt = 1'b0, m_after_rst = 1'b1, m_acc = 1'b0;
    int m_A, m_S, m_F, m_D;
    int first_start = -1, first_done = -1;

    function automatic logic [LOGQ-1:0] f0(input logic [LOGQ-1:0] x);
        return x * 16'd3 + 16'd5;
    endfunction
    function automatic logic [LOGQ-1:0] f1(input logic [LOGQ-1:0] x);
        return {x[7:0], x[15:8]} ^ 16'hA5A5;
    endfunction

    // ---------------- scoreboard check ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic randomize_mem();
        for (int i = 0; i < NP; i++) begin
            mem0[i] = 16'($urandom);
            mem1[i] = 16'($urandom);
        end
    endtask

    // Expected outputs for the current cycle from the op timeline, then
    // advance the timeline with this cycle's inputs.
    task automatic model_check();
        bit act, e_rd, e_st, e_in, e_wr, e_dn;
        int c;
        c    = cyc;
        act  = m_act && (c > m_A) && (c <= m_D);
        e_rd = m_act && (c >= m_A + 1) && (c <= m_A + NP);
        e_st = m_act && (c == m_S);
        e_in = m_act && (c >= m_S) && (c < m_S + NP);
        e_wr = m_act && (m_F >= 0) && (c >= m_F) && (c < m_F + NP);
        e_dn = m_act && (c == m_D);

        check("cmd_ready", 64'(cmd_ready), 64'(!act));
        check("busy", 64'(busy), 64'(act));
        check("rd_en", 64'(rd_en), 64'(e_rd));
        if (e_rd) check("rd_addr", 64'(rd_addr), 64'(c - m_A - 1));
        check("ntt_start", 64'(ntt_start), 64'(e_st));
        check("ntt_in_0", 64'(ntt_in_0), e_in ? 64'(mem0[c - m_S]) : 64'd0);
        check("ntt_in_1", 64'(ntt_in_1), e_in ? 64'(mem1[c - m_S]) : 64'd0);
        check("wr_en", 64'(wr_en), 64'(e_wr));
        if (e_wr) begin
            check("wr_addr", 64'(wr_addr), 64'(c - m_F));
            check("wr_data_0", 64'(wr_data_0), 64'(f0(mem0[c - m_F])));
            check("wr_data_1", 64'(wr_data_1), 64'(f1(mem1[c - m_F])));
        end
        check("done", 64'(done), 64'(e_dn));
        check("err", 64'(err), 64'(e_dn && (m_F < 0)));
        check("ntt_intt", 64'(ntt_intt), 64'(m_intt));
        if (!act) check("idle_state", 64'(dbg_state), 64'(ST_IDLE));
        if (m_after_rst) begin
            check("rst_rd_addr", 64'(rd_addr), 64'd0);
            check("rst_wr_addr", 64'(wr_addr), 64'd0);
            check("rst_wr_data", 64'({wr_data_1, wr_data_0}), 64'd0);
        end

        m_acc       = 1'b0;
        m_after_rst = n_rst;
        if (n_rst) begin
            m_act  = 1'b0;
            m_intt = 1'b0;
        end else if (n_valid && !act) begin
            m_act  = 1'b1;
            m_acc  = 1'b1;
            m_intt = n_intt;
            m_A    = c;
            m_S    = c + 1 + D;
            m_F    = p_fin_en ? m_S + LAT : -1;
            m_D    = (m_F >= 0) ? m_F + NP : m_S + TMO + 1;
        end
    endtask

    // ---------------- driver: one clock cycle ----------------
    task automatic step();
        int k;
        @(posedge clk);
        cyc++;
        #1;
        rst       = n_rst;
        cmd_valid = n_valid;
        cmd_intt  = n_intt;
        if (cyc >= D && cyc - D < HMAX && h_rd_en[cyc - D]) begin
            rd_data_0 = mem0[h_rd_addr[cyc - D]];
            rd_data_1 = mem1[h_rd_addr[cyc - D]];
        end else begin
            rd_data_0 = 16'($urandom);
            rd_data_1 = 16'($urandom);
        end
        k = cyc - p_s - LAT;
        if (p_fin_en && k >= 0 && k < NP) begin
            ntt_finish = (k == 0);
            ntt_out_0  = f0(cap0[k]);
            ntt_out_1  = f1(cap1[k]);
        end else begin
            ntt_finish = n_spur;
            ntt_out_0  = 16'($urandom);
            ntt_out_1  = 16'($urandom);
        end
        @(negedge clk);
        if (cyc < HMAX) begin
            h_rd_en[cyc]   = rd_en;
            h_rd_addr[cyc] = rd_addr;
        end
        if (ntt_start && first_start < 0) first_start = cyc;
        if (done && first_done < 0) first_done = cyc;
        model_check();
        if (ntt_start) p_s = cyc;
        if (cyc - p_s >= 0 && cyc - p_s < NP) begin
            cap0[cyc - p_s] = ntt_in_0;
            cap1[cyc - p_s] = ntt_in_1;
        end
    endtask

    task automatic issue(input logic intt);
        int n;
        randomize_mem();
        n_valid = 1'b1;
        n_intt  = intt;
        n = 0;
        do begin
            step();
            n++;
        end while (!m_acc && n < 200);
        if (!m_acc) check("accept_bound", 64'd1, 64'd0);
        n_valid = 1'b0;
        n_intt  = 1'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (m_act && cyc <= m_D && n < 300) begin
            step();
            n++;
        end
        if (n >= 300) check("idle_bound", 64'd1, 64'd0);
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // ---------------- scenarios ----------------
    initial begin
        int accepts, n;
        randomize_mem();
        idle(3);
        n_rst = 1'b0;
        while (cyc < 9) step();

        // forward op accepted at cycle 10
        n_valid = 1'b1;
        n_intt  = 1'b0;
        step();
        n_valid = 1'b0;
        wait_idle();
        check("first_start_cyc", 64'(first_start), 64'd13);
        check("first_done_cyc", 64'(first_done), 64'd41);

        // inverse op, cmd_intt dropped right after accept
        idle(3);
        issue(1'b1);
        n_intt = 1'b0;
        wait_idle();

        // cmd_valid held through an op: back-to-back accept after done
        idle(2);
        randomize_mem();
        n_valid = 1'b1;
        n_intt  = 1'b1;
        accepts = 0;
        n = 0;
        while (accepts < 2 && n < 300) begin
            step();
            n++;
            if (m_acc) accepts++;
        end
        if (accepts < 2) check("b2b_bound", 64'd1, 64'd0);
        n_valid = 1'b0;
        wait_idle();

        // pipeline never finishes: timeout abort
        idle(2);
        p_fin_en = 1'b0;
        issue(1'($urandom));
        wait_idle();
        p_fin_en = 1'b1;
        p_s      = -1000;

        // reset mid-FEED; the stale pipeline finish later lands in IDLE
        idle(2);
        issue(1'b1);
        idle(4);
        n_rst = 1'b1;
        step();
        n_rst = 1'b0;
        idle(40);

        // spurious finish while idle
        n_spur = 1'b1;
        step();
        n_spur = 1'b0;
        idle(4);

        // randomized ops
        for (int i = 0; i < 6; i++) begin
            idle($urandom_range(0, 5));
            issue(1'($urandom));
            wait_idle();
        end
        idle(3);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
